// File: rtl/fft_bitrev_reorder_if.sv
// Sample/pair stream bundle for the bit-reversal reorder stage.
// The slave side is the reorder block: it consumes natural-order samples
// and produces butterfly pairs plus the mid-frame start-of-frame pulse.
interface fft_bitrev_reorder_if #(
    parameter int DW = 32
);
    logic          sop_i;
    logic          data_in_flag_i;
    logic [DW-1:0] data_real_i;
    logic [DW-1:0] data_imag_i;
    logic          data_out_flag_o;
    logic [DW-1:0] data1_real_o;
    logic [DW-1:0] data1_imag_o;
    logic [DW-1:0] data2_real_o;
    logic [DW-1:0] data2_imag_o;
    logic          frame_err_o;

    modport master (
        output sop_i, data_in_flag_i, data_real_i, data_imag_i,
        input  data_out_flag_o, data1_real_o, data1_imag_o,
               data2_real_o, data2_imag_o, frame_err_o
    );

    modport slave (
        input  sop_i, data_in_flag_i, data_real_i, data_imag_i,
        output data_out_flag_o, data1_real_o, data1_imag_o,
               data2_real_o, data2_imag_o, frame_err_o
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversal reorder stage in front of the radix-2 butterfly.
// Samples arrive one per valid cycle in natural order and are written into a
// ping-pong buffer at bit-reversed positions. Each bank is split into an even
// and an odd half so that butterfly pair k (even[k], odd[k]) is read in a
// single cycle. A finished bank is handed to a two-state reader that drains
// N/2 pairs on consecutive cycles.
module fft_bitrev_reorder #(
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int DW    = 32
) (
    input  logic                 sys_clk_i,
    input  logic                 rst_n_i,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int AW   = LOG2N - 1;   // address width inside one half
    localparam int HALF = N / 2;

    typedef enum logic {IDLE, READ} rd_state_t;

    // Reverse the AW low index bits; the index MSB selects the half instead.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // ---------------- write side ----------------
    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic [LOG2N-1:0] wr_n;
    logic             wr_en;
    logic             wr_last;
    logic             wr_half;
    logic [AW-1:0]    wr_addr;
    logic             sop_restart;
    logic             frame_err;

    // Decode the accepted sample: sop forces index 0, the last index hands off.
    // NOTE: every always_comb output gets a default first so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        wr_en       = bus.data_in_flag_i;
        wr_n        = bus.sop_i ? '0 : wr_cnt;
        wr_half     = wr_n[LOG2N-1];
        wr_addr     = bitrev(wr_n[AW-1:0]);
        wr_last     = wr_en && (wr_n == LOG2N'(N - 1));
        sop_restart = wr_en && bus.sop_i && (wr_cnt != '0);
    end

    // Sample counter, ping-pong bank select and the mid-frame sop pulse.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= sop_restart;
            if (wr_en) begin
                wr_cnt <= wr_n + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
        end
    end

    // ---------------- storage ----------------
    // Each entry packs {imag, real}.
    logic [2*DW-1:0] mem_even [2][HALF];
    logic [2*DW-1:0] mem_odd  [2][HALF];

    // Write the sample into the even or odd half of the filling bank.
    // NOTE: the buffer has no reset; every entry is rewritten before a bank is
    // handed to the reader, so stale contents are never observed.
    always_ff @(posedge sys_clk_i) begin
        if (wr_en) begin
            if (wr_half) mem_odd[wr_bank][wr_addr]  <= {bus.data_imag_i, bus.data_real_i};
            else         mem_even[wr_bank][wr_addr] <= {bus.data_imag_i, bus.data_real_i};
        end
    end

    // ---------------- reader ----------------
    rd_state_t     state, state_nx;
    logic [AW-1:0] rd_addr, rd_addr_nx;
    logic          rd_bank, rd_bank_nx;
    logic          pend, pend_nx;
    logic          pend_bank, pend_bank_nx;
    logic          rd_en;

    // Next-state logic: drain one pair per cycle, chain straight into a
    // pending or simultaneous handoff so no completed frame is ever lost.
    always_comb begin
        state_nx     = state;
        rd_addr_nx   = rd_addr;
        rd_bank_nx   = rd_bank;
        pend_nx      = pend;
        pend_bank_nx = pend_bank;
        rd_en        = 1'b0;
        case (state)
            IDLE: begin
                if (wr_last) begin
                    state_nx   = READ;
                    rd_addr_nx = '0;
                    rd_bank_nx = wr_bank;
                end
            end
            READ: begin
                rd_en      = 1'b1;
                rd_addr_nx = rd_addr + 1'b1;   // wraps to 0 after the last pair
                if (rd_addr == AW'(HALF - 1)) begin
                    if (pend) begin
                        rd_bank_nx   = pend_bank;
                        pend_nx      = wr_last;
                        pend_bank_nx = wr_bank;
                    end else if (wr_last) begin
                        rd_bank_nx = wr_bank;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (wr_last) begin
                    pend_nx      = 1'b1;
                    pend_bank_nx = wr_bank;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reader state register.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            rd_addr   <= '0;
            rd_bank   <= 1'b0;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
        end else begin
            state     <= state_nx;
            rd_addr   <= rd_addr_nx;
            rd_bank   <= rd_bank_nx;
            pend      <= pend_nx;
            pend_bank <= pend_bank_nx;
        end
    end

    // ---------------- output ----------------
    logic          out_flag;
    logic [DW-1:0] d1_re, d1_im, d2_re, d2_im;

    // Registered pair output; data holds its last value while the flag is low.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_flag <= 1'b0;
            d1_re    <= '0;
            d1_im    <= '0;
            d2_re    <= '0;
            d2_im    <= '0;
        end else begin
            out_flag <= rd_en;
            if (rd_en) begin
                {d1_im, d1_re} <= mem_even[rd_bank][rd_addr];
                {d2_im, d2_re} <= mem_odd[rd_bank][rd_addr];
            end
        end
    end

    assign bus.data_out_flag_o = out_flag;
    assign bus.data1_real_o    = d1_re;
    assign bus.data1_imag_o    = d1_im;
    assign bus.data2_real_o    = d2_re;
    assign bus.data2_imag_o    = d2_im;
    assign bus.frame_err_o     = frame_err;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder. Two instances (N=8 and N=16) see
// the same sample stream; a frame-level reference model per instance pushes
// expected pairs (with their expected cycle) and expected frame_err cycles,
// and a negedge monitor pops and compares.
module tb_fft_bitrev_reorder;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] r1, i1, r2, i2;
    } pair_t;
    typedef struct {
        pair_t       p;
        int unsigned cyc;
    } exp_t;
    typedef struct {
        logic [DW-1:0] re, im;
    } samp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc   = 0;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bitrev_reorder_if #(.DW(DW)) bus8 ();
    fft_bitrev_reorder_if #(.DW(DW)) bus16 ();

    fft_bitrev_reorder #(.N(8),  .LOG2N(3), .DW(DW)) dut8  (.sys_clk_i(clk), .rst_n_i(rst_n), .bus(bus8));
    fft_bitrev_reorder #(.N(16), .LOG2N(4), .DW(DW)) dut16 (.sys_clk_i(clk), .rst_n_i(rst_n), .bus(bus16));

    // ---------------- reference model state ----------------
    samp_t       fr8[$], fr16[$];     // samples of the frame being collected
    exp_t        q8[$], q16[$];       // expected output pairs
    int unsigned eq8[$], eq16[$];     // expected frame_err cycles
    pair_t       last8 = '0, last16 = '0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++)
            if (v & (1 << b)) r |= 1 << (bits - 1 - b);
        return r;
    endfunction

    // Sample accepted on posedge number e: a completed frame yields pair k =
    // (x[bitrev(2k)], x[bitrev(2k+1)]) visible from cycle e+1+k, i.e. two
    // cycles after the accepting cycle (e-1). A mid-frame sop yields an error
    // pulse in the cycle after the accepting cycle.
    task automatic model_accept(input int d, input logic sop, input samp_t s, input int unsigned e);
        samp_t fr[$];
        exp_t  x;
        int    n, lg;
        n  = (d == 0) ? 8 : 16;
        lg = (d == 0) ? 3 : 4;
        if (d == 0) fr = fr8; else fr = fr16;
        if (sop) begin
            if (fr.size() != 0) begin
                if (d == 0) eq8.push_back(e); else eq16.push_back(e);
            end
            fr.delete();
        end
        fr.push_back(s);
        if (fr.size() == n) begin
            for (int k = 0; k < n / 2; k++) begin
                x.p   = '{fr[bitrev(2*k, lg)].re, fr[bitrev(2*k, lg)].im,
                          fr[bitrev(2*k+1, lg)].re, fr[bitrev(2*k+1, lg)].im};
                x.cyc = e + 1 + k;
                if (d == 0) q8.push_back(x); else q16.push_back(x);
            end
            fr.delete();
        end
        if (d == 0) fr8 = fr; else fr16 = fr;
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int d, input logic flag, input logic err, input pair_t got);
        string       tag;
        int          qs, es;
        int unsigned eh, xh, ec;
        exp_t        x;
        pair_t       lst;
        tag = (d == 0) ? "n8" : "n16";
        eh  = 0;
        xh  = 0;
        if (d == 0) begin qs = q8.size();  es = eq8.size();  lst = last8;  end
        else        begin qs = q16.size(); es = eq16.size(); lst = last16; end
        if (es > 0) eh = (d == 0) ? eq8[0] : eq16[0];
        if (qs > 0) xh = (d == 0) ? q8[0].cyc : q16[0].cyc;

        if (err || (es > 0 && eh < cyc)) begin
            if (es == 0) check({tag, " frame_err_unexpected"}, 160'(err), 160'(0));
            else begin
                if (d == 0) ec = eq8.pop_front(); else ec = eq16.pop_front();
                check({tag, " frame_err_cycle"}, 160'(cyc), 160'(ec));
            end
        end

        if (flag || (qs > 0 && xh < cyc)) begin
            if (qs == 0) begin
                check({tag, " valid_unexpected"}, 160'(flag), 160'(0));
                lst = got;
            end else begin
                if (d == 0) x = q8.pop_front(); else x = q16.pop_front();
                check({tag, " pair_cycle"}, 160'(cyc), 160'(x.cyc));
                if (flag) begin
                    check({tag, " pair_data"}, 160'(got), 160'(x.p));
                    lst = got;
                end
            end
        end else begin
            check({tag, " hold"}, 160'(got), 160'(lst));
        end
        if (d == 0) last8 = lst; else last16 = lst;
    endtask

    always @(negedge clk) begin
        mon(0, bus8.data_out_flag_o, bus8.frame_err_o,
            {bus8.data1_real_o, bus8.data1_imag_o, bus8.data2_real_o, bus8.data2_imag_o});
        mon(1, bus16.data_out_flag_o, bus16.frame_err_o,
            {bus16.data1_real_o, bus16.data1_imag_o, bus16.data2_real_o, bus16.data2_imag_o});
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic flag, input logic sop, input logic [DW-1:0] re, input logic [DW-1:0] im);
        bus8.data_in_flag_i  = flag;  bus16.data_in_flag_i = flag;
        bus8.sop_i           = sop;   bus16.sop_i          = sop;
        bus8.data_real_i     = re;    bus16.data_real_i    = re;
        bus8.data_imag_i     = im;    bus16.data_imag_i    = im;
    endtask

    task automatic send(input logic sop, input logic [DW-1:0] re, input logic [DW-1:0] im);
        samp_t s;
        s = '{re, im};
        drive(1'b1, sop, re, im);
        @(posedge clk); #1;
        model_accept(0, sop, s, cyc);
        model_accept(1, sop, s, cyc);
        drive(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int rbase, input int ibase, input int len, input bit with_sop, input bit gaps);
        for (int i = 0; i < len; i++) begin
            send(with_sop && i == 0, DW'(rbase + i), DW'(ibase + i));
            if (gaps) idle(1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("n8 reset_outputs", {bus8.data_out_flag_o, bus8.frame_err_o, bus8.data1_real_o,
              bus8.data1_imag_o, bus8.data2_real_o, bus8.data2_imag_o}, '0);
        check("n16 reset_outputs", {bus16.data_out_flag_o, bus16.frame_err_o, bus16.data1_real_o,
              bus16.data1_imag_o, bus16.data2_real_o, bus16.data2_imag_o}, '0);
        q8.delete();  q16.delete();
        eq8.delete(); eq16.delete();
        fr8.delete(); fr16.delete();
        last8 = '0;   last16 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0);
        #2;
        do_reset();
        idle(2);

        // T1: gapless frame with sop, real=n, imag=100+n
        frame(0, 100, 8, 1'b1, 1'b0);
        idle(8);
        // T2: same frame, valid toggling 1/0
        frame(0, 100, 8, 1'b1, 1'b1);
        idle(8);
        // T3: back-to-back frames, second frame starts by counter wrap
        frame(0, 200, 8, 1'b1, 1'b0);
        frame(10, 300, 8, 1'b0, 1'b0);
        idle(10);
        // T4: three samples, then a mid-frame sop starting real=50
        frame(20, 400, 3, 1'b1, 1'b0);
        frame(50, 500, 8, 1'b1, 1'b0);
        idle(10);
        // T5: reset while pair k=1 is on the output, then a clean T1 frame
        frame(0, 100, 8, 1'b1, 1'b0);
        idle(2);
        do_reset();
        idle(2);
        frame(0, 100, 8, 1'b1, 1'b0);
        idle(8);
        // T6: 16-sample frame, real=n, for the N=16 instance
        frame(0, 600, 16, 1'b1, 1'b0);
        idle(12);

        // Random data, random gaps and occasional sops (some mid-frame)
        for (int i = 0; i < 120; i++) begin
            send($urandom_range(0, 19) == 0, $urandom, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(20);

        check("n8 pairs_left",      160'(q8.size()),   160'(0));
        check("n16 pairs_left",     160'(q16.size()),  160'(0));
        check("n8 frame_err_left",  160'(eq8.size()),  160'(0));
        check("n16 frame_err_left", 160'(eq16.size()), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Input reorder stage directly upstream of the radix-2 butterfly (my_fft_n2).
- Accepts one complex sample per valid cycle in natural order and stores each frame of N samples at bit-reversed addresses in a ping-pong buffer.
- Drains each completed frame as N/2 butterfly pairs, one pair per cycle, in the format the butterfly consumes.
- Decouples the serial sample source from the pair-wide first DIT stage.

Parameters:
- N, 8, frame length in complex samples; power of 2, 4..1024.
- LOG2N, 3, log2(N); must equal $clog2(N).
- DW, 32, width of each real/imag component.

Ports:
- sys_clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- sop_i  in  1  start of frame; qualified by data_in_flag_i.
- data_in_flag_i  in  1  input sample valid.
- data_real_i  in  DW  input sample, real part.
- data_imag_i  in  DW  input sample, imaginary part.
- data_out_flag_o  out  1  output pair valid.
- data1_real_o  out  DW  pair element 1 (even bit-reversed slot), real part.
- data1_imag_o  out  DW  pair element 1, imaginary part.
- data2_real_o  out  DW  pair element 2 (odd bit-reversed slot), real part.
- data2_imag_o  out  DW  pair element 2, imaginary part.
- frame_err_o  out  1  one-cycle pulse: sop_i arrived mid-frame.

Behaviour:
- Reset (rst_n_i=0, async): all outputs 0, write count 0, write bank 0, reader idle, no frame pending.
- Storage: 2 banks; each bank is 2 halves (even, odd) of N/2 x 2*DW.
- Write n (0..N-1): half = n[LOG2N-1] (MSB); address = bitrev(n[LOG2N-2:0]).
- Consequence: bitrev(n) = 2*addr + half. Pair k reads even[k] and odd[k] in the same cycle.
- Write counter advances on each data_in_flag_i=1; data_in_flag_i=0 cycles are ignored (gaps allowed).
- sop_i=1 with data_in_flag_i=1: sample written as n=0.
  - If count was nonzero, the partial frame is discarded and frame_err_o pulses in the following cycle.
  - sop_i with data_in_flag_i=0 is ignored.
- sop_i is not required; the counter wraps N-1 -> 0 and a new frame starts implicitly.
- Frame completion: the cycle n=N-1 is written, the write bank toggles and the just-filled bank is handed to the reader.
- Reader FSM states: IDLE, READ.
  - IDLE -> READ on handoff.
  - READ outputs k = 0..N/2-1 on consecutive cycles; READ -> IDLE after k=N/2-1, or stays in READ if another handoff is pending.
- Latency: the first pair has data_out_flag_o=1 exactly 2 cycles after the cycle sample N-1 is accepted (registered read address, registered output).
- Output flag is high for exactly N/2 contiguous cycles per frame. Outputs hold their last value when the flag is 0.
- No overrun is possible: a fill takes >= N cycles and a drain takes N/2 cycles.
  - Back-to-back gapless frames give N/2 valid cycles then N/2 idle cycles.
- Simultaneous last write of frame F+1 and read of frame F: impossible by the rate argument above. A one-deep pending flag is still required; the handoff is never dropped.
- No backpressure: the downstream butterfly accepts every valid cycle.
- Reset mid-operation: the in-flight frame and any pending drain are discarded; the first post-reset frame starts at n=0.

Test Plan:
- T1, N=8: sop at n=0, real=n, imag=100+n, gapless -> 4 pairs (0,4),(2,6),(1,5),(3,7), imag (100,104),(102,106),(101,105),(103,107); first valid 2 cycles after n=7 accepted; flag high 4 cycles.
- T2, gaps: same frame with data_in_flag_i toggling 1/0 -> identical pairs; latency measured from the n=7 accept cycle is still 2.
- T3, back-to-back: frames A (real=n) and B (real=10+n) gapless -> A pairs, 4 idle cycles, then B pairs (10,14),(12,16),(11,15),(13,17); no corruption of A.
- T4, mid-frame sop: 3 samples, then sop with real=50.. for 8 samples -> frame_err_o pulses once; output pairs (50,54),(52,56),(51,55),(53,57) only.
- T5, reset: assert rst_n_i while draining pair k=1 -> all outputs 0 asynchronously; a clean frame afterwards reproduces T1 exactly.
- T6, N=16 regression: real=n -> pair k = (bitrev4(2k), bitrev4(2k+1)), e.g. k=0 (0,8), k=1 (4,12), k=7 (7,15).
